cpu_control_unit: RTL and testbench

Synthesizable sequencer for the accumulator CPU datapath. It owns PC, IR, MAR, MBR and AC, and runs fetch/decode/execute. It drives the single-port synchronous RAM (addr/data/cs/we/oe) and the external ALU (A, B, sel). It replaces behavioural sequencing in benches with a real FSM; benches only preload RAM and pulse start.

---
 rtl/cpu_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator CPU: owns PC, IR, MAR, MBR, AC and
// drives a single-port synchronous RAM plus an external combinational ALU.
module cpu_control_unit #(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100,
    parameter int unsigned           PC_STEP    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  halted,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [3:0]            state_dbg
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_LOAD_IR, ST_DECODE, ST_RD, ST_LATCH, ST_ALU,
        ST_WB, ST_ST_ADDR, ST_ST_WR, ST_EXEC, ST_HALT
    } state_e;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_BACK  = 4'h8;
    localparam logic [3:0] OP_SKIP  = 4'h9;
    localparam logic [3:0] OP_JUMP  = 4'hA;
    localparam logic [3:0] OP_CLEAR = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d;
    logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic                  halted_q, halted_d, busy_q, busy_d;
    logic [3:0]            sel_q, sel_d;

    logic [3:0]            op, op_d;
    logic [ADDR_WIDTH-1:0] operand;
    logic                  skip;
    logic                  rd_state;

    assign op      = ir_q[15:12];
    assign op_d    = ir_d[15:12];
    assign operand = ADDR_WIDTH'(ir_q[11:0]);

    always_comb begin
        unique case (ir_q[11:10])
            2'b00:   skip = ac_q[DATA_WIDTH-1];
            2'b01:   skip = (ac_q == '0);
            2'b10:   skip = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
            default: skip = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        ac_d    = ac_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_LOAD_IR;
            ST_LOAD_IR: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + STEP;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (op == OP_LOAD || (op >= OP_ADD && op <= OP_NOT)) begin
                    mar_d   = operand;
                    state_d = ST_RD;
                end else if (op == OP_STORE) begin
                    state_d = ST_ST_ADDR;
                end else if (op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_RD:      state_d = ST_LATCH;
            ST_LATCH: begin
                mbr_d   = mem_rdata;
                state_d = (op == OP_LOAD) ? ST_WB : ST_ALU;
            end
            ST_ALU:     state_d = ST_WB;
            ST_WB: begin
                ac_d    = (op == OP_LOAD) ? mbr_q : alu_out;
                state_d = ST_FETCH;
            end
            ST_ST_ADDR: begin
                mar_d   = operand;
                mbr_d   = ac_q;
                state_d = ST_ST_WR;
            end
            ST_ST_WR:   state_d = ST_FETCH;
            ST_EXEC: begin
                case (op)
                    OP_BACK:  pc_d = pc_q - STEP;
                    OP_SKIP:  if (skip) pc_d = pc_q + STEP;
                    OP_JUMP:  pc_d = operand;
                    OP_CLEAR: ac_d = '0;
                    default:  ;
                endcase
                state_d = ST_FETCH;
            end
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase
        // MAR must already hold the fetch address while FETCH is presenting the read.
        if (state_d == ST_FETCH) mar_d = pc_d;
    end

    assign rd_state = (state_d == ST_FETCH) || (state_d == ST_LOAD_IR) ||
                      (state_d == ST_RD) || (state_d == ST_LATCH);

    always_comb begin
        cs_d     = rd_state || (state_d == ST_ST_WR);
        we_d     = (state_d == ST_ST_WR);
        oe_d     = rd_state;
        halted_d = (state_d == ST_HALT);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALT);
        sel_d    = 4'd0;
        if ((state_d == ST_ALU || state_d == ST_WB) && op_d >= OP_ADD && op_d <= OP_NOT)
            sel_d = op_d - 4'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mar_q    <= '0;
            mbr_q    <= '0;
            ac_q     <= '0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            sel_q    <= 4'd0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            mbr_q    <= mbr_d;
            ac_q     <= ac_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            sel_q    <= sel_d;
            halted_q <= halted_d;
            busy_q   <= busy_d;
        end
    end

    assign mem_addr  = mar_q;
    assign mem_wdata = mbr_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_oe    = oe_q;
    assign alu_a     = ac_q;
    assign alu_b     = mbr_q;
    assign alu_sel   = sel_q;
    assign halted    = halted_q;
    assign busy      = busy_q;
    assign pc        = pc_q;
    assign ac        = ac_q;
    assign ir        = ir_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: RAM and ALU models, directed programs, and a monitor that
// pops expected RAM writes and halt snapshots from queues as the DUT produces them.
module tb_cpu_control_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_cs, mem_we, mem_oe;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        halted, busy;
    logic [11:0] pc;
    logic [15:0] ac, ir;
    logic [3:0]  state_dbg;

    cpu_control_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .halted(halted), .busy(busy), .pc(pc), .ac(ac), .ir(ir), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM and ALU models ----------------
    logic [15:0] ram [4096];
    logic        pl_en = 1'b0, pl_clr = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= '0;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_cs && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_cs && mem_oe && !mem_we) mem_rdata <= ram[mem_addr];
    end

    always_comb begin
        case (alu_sel)
            4'd1:    alu_out = alu_a + alu_b;
            4'd2:    alu_out = alu_a - alu_b;
            4'd3:    alu_out = alu_a & alu_b;
            4'd4:    alu_out = alu_a | alu_b;
            4'd5:    alu_out = ~alu_a;
            default: alu_out = '0;
        endcase
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [11:0] pc;
        logic [15:0] ac;
        int          busy;
        int          alu;
    } halt_t;

    logic [27:0] exp_q[$];
    halt_t       halt_q[$];
    logic [15:0] prog_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          busy_cnt = 0;
    int          alu_cnt = 0;
    logic        halted_prev = 1'b0;
    halt_t       mon_h;
    logic [27:0] mon_w;

    always @(negedge clk) begin
        if (start) begin
            busy_cnt = 0;
            alu_cnt  = 0;
        end
        if (busy) busy_cnt++;
        if (alu_sel != 4'd0) begin
            alu_cnt++;
            check("alu_sel_vs_opcode", {28'd0, alu_sel}, {28'd0, ir[15:12] - 4'd2});
        end
        if (mem_cs) check("we_oe_exclusive", {31'd0, mem_we & mem_oe}, 32'd0);
        if (mem_cs && mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                mon_w = exp_q.pop_front();
                check("ram_write", {4'd0, mem_addr, mem_wdata}, {4'd0, mon_w});
            end
        end
        if (halted && !halted_prev) begin
            if (halt_q.size() == 0) begin
                check("unexpected_halt", {31'd0, halted}, 32'd0);
            end else begin
                mon_h = halt_q.pop_front();
                check("halt_pc", {20'd0, pc}, {20'd0, mon_h.pc});
                check("halt_ac", {16'd0, ac}, {16'd0, mon_h.ac});
                check("busy_cycles", busy_cnt, mon_h.busy);
                check("alu_cycles", alu_cnt, mon_h.alu);
            end
        end
        halted_prev = halted;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_ram();
        @(posedge clk); #1 pl_clr = 1'b1;
        @(posedge clk); #1 pl_clr = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1 pl_en = 1'b0;
    endtask

    task automatic load_prog(input logic [11:0] base);
        for (int i = 0; i < prog_q.size(); i++) poke(base + 12'(2 * i), prog_q[i]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic expect_halt(input logic [11:0] p, input logic [15:0] a, input int b, input int u);
        halt_q.push_back('{pc: p, ac: a, busy: b, alu: u});
    endtask

    task automatic finish_test(input string name);
        int n = 0;
        while (!halted && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
        repeat (2) @(negedge clk);
        check({name, "_writes_drained"}, exp_q.size(), 0);
        check({name, "_halts_drained"}, halt_q.size(), 0);
        exp_q.delete();
        halt_q.delete();
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] fa, fb, ft, fn;

    initial begin
        // Reset in the middle of a Store: no write may follow, state returns to reset values.
        do_reset();
        clear_ram();
        prog_q = '{16'h2124, 16'hF000};
        load_prog(12'h100);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_pc", {20'd0, pc}, 32'h100);
        check("rst_ac", {16'd0, ac}, 32'h0);
        check("rst_ir", {16'd0, ir}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_mem_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
        check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back({12'h124, 16'h0000});
        expect_halt(12'h104, 16'h0000, 8, 0);
        pulse_start();
        @(negedge clk);
        check("fetch_addr", {20'd0, mem_addr}, 32'h100);
        check("fetch_ctl", {29'd0, mem_cs, mem_we, mem_oe}, {29'd0, 3'b101});
        finish_test("store_after_reset");

        // Load / Add / Store / Halt: 6+7+5 cycles plus 3 busy cycles before HALT.
        do_reset();
        clear_ram();
        prog_q = '{16'h1120, 16'h3122, 16'h2124, 16'hF000};
        load_prog(12'h100);
        poke(12'h120, 16'h0005);
        poke(12'h122, 16'hFFFE);
        exp_q.push_back({12'h124, 16'h0003});
        expect_halt(12'h108, 16'h0003, 21, 2);
        pulse_start();
        finish_test("load_add_store");
        check("ram_124", {16'd0, ram[12'h124]}, 32'h3);

        // Skip when AC == 0.
        do_reset();
        clear_ram();
        prog_q = '{16'hB000, 16'h9400, 16'hF000, 16'hF000};
        load_prog(12'h100);
        expect_halt(12'h108, 16'h0000, 11, 0);
        pulse_start();
        finish_test("skip_zero");

        // AC negative: 9000 skips, 9800 and 9C00 do not.
        do_reset();
        clear_ram();
        prog_q = '{16'h1120, 16'h9000, 16'hF000, 16'h9800, 16'h9C00, 16'hF000, 16'hF000};
        load_prog(12'h100);
        poke(12'h120, 16'h8000);
        expect_halt(12'h10C, 16'h8000, 21, 0);
        pulse_start();
        finish_test("skip_negative");

        // AC positive: 9800 skips, 9000 and 9400 do not.
        do_reset();
        clear_ram();
        prog_q = '{16'h1120, 16'h9800, 16'hF000, 16'h9000, 16'h9400, 16'hF000, 16'hF000};
        load_prog(12'h100);
        poke(12'h120, 16'h0001);
        expect_halt(12'h10C, 16'h0001, 21, 0);
        pulse_start();
        finish_test("skip_positive");

        // Jump to 108, then Back at 108 re-fetches 108 forever; observe two fetches then reset.
        do_reset();
        clear_ram();
        poke(12'h100, 16'hA108);
        poke(12'h108, 16'h8000);
        pulse_start();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 5) check("jump_fetch_addr", {20'd0, mem_addr}, 32'h108);
            if (i == 9) begin
                check("back_fetch_addr", {20'd0, mem_addr}, 32'h108);
                check("back_pc", {20'd0, pc}, 32'h108);
                check("back_ir", {16'd0, ir}, 32'h8000);
                check("back_busy", {31'd0, busy}, 32'd1);
            end
        end

        // PC wrap: jump to FFE, NOP there, next fetch at 000 which halts.
        do_reset();
        clear_ram();
        poke(12'h100, 16'hAFFE);
        poke(12'hFFE, 16'h0000);
        poke(12'h000, 16'hF000);
        expect_halt(12'h002, 16'h0000, 11, 0);
        pulse_start();
        finish_test("pc_wrap");

        // Sub / And / Or / Not with AC=00F0, M=0F0F, each result stored.
        do_reset();
        clear_ram();
        prog_q = '{16'h1120, 16'h4122, 16'h2130, 16'h1120, 16'h5122, 16'h2132,
                   16'h1120, 16'h6122, 16'h2134, 16'h1120, 16'h7122, 16'h2136, 16'hF000};
        load_prog(12'h100);
        poke(12'h120, 16'h00F0);
        poke(12'h122, 16'h0F0F);
        exp_q.push_back({12'h130, 16'hF1E1});
        exp_q.push_back({12'h132, 16'h0000});
        exp_q.push_back({12'h134, 16'h0FFF});
        exp_q.push_back({12'h136, 16'hFF0F});
        expect_halt(12'h11A, 16'hFF0F, 75, 8);
        pulse_start();
        finish_test("alu_ops");

        // Fibonacci: five iterations of T=A+B; A=B; B=T; N++ with a skip-on-zero exit.
        do_reset();
        clear_ram();
        prog_q = '{16'h1140, 16'h3142, 16'h2144, 16'h1142, 16'h2140, 16'h1144, 16'h2142,
                   16'h1146, 16'h3148, 16'h2146, 16'h9400, 16'hA100, 16'hF000};
        load_prog(12'h100);
        poke(12'h140, 16'h0000);
        poke(12'h142, 16'h0001);
        poke(12'h146, 16'hFFFB);
        poke(12'h148, 16'h0001);
        fa = 16'h0000;
        fb = 16'h0001;
        fn = 16'hFFFB;
        for (int i = 0; i < 5; i++) begin
            ft = fa + fb;
            fn = fn + 16'h1;
            exp_q.push_back({12'h144, ft});
            exp_q.push_back({12'h140, fb});
            exp_q.push_back({12'h142, ft});
            exp_q.push_back({12'h146, fn});
            fa = fb;
            fb = ft;
        end
        // Loop body is 66 cycles, the last pass skips the jump (62), then 3 for the halt fetch.
        expect_halt(12'h11A, 16'h0000, 4 * 66 + 62 + 3, 20);
        pulse_start();
        finish_test("fibonacci");
        check("fib_a", {16'd0, ram[12'h140]}, {16'd0, fa});
        check("fib_b", {16'd0, ram[12'h142]}, {16'd0, fb});
        check("fib_n", {16'd0, ram[12'h146]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
